// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types, burst encodings and arbiter state encoding.
// Imported by the arbiter top and its round-robin picker.
package cbus_arbiter_pkg;

  localparam int CBUS_AW = 32;
  localparam int CBUS_DW = 64;
  localparam int CBUS_SW = CBUS_DW / 8;
  localparam int CBUS_LW = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_e;

  typedef struct packed {
    logic               valid;
    logic               is_write;
    logic [2:0]         size;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_SW-1:0] strobe;
    logic [CBUS_DW-1:0] data;
    logic [CBUS_LW-1:0] len;
    cbus_burst_e        burst;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 1'b0;
  localparam arb_state_t ARB_BUSY = 1'b1;

  // Beat counter decrement that holds at zero.
  function automatic logic [CBUS_LW-1:0] beat_dec(
    input logic [CBUS_LW-1:0] cnt
  );
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational winner picker for the cbus arbiter.
// Round-robin searches from last+1 with wrap; fixed takes lowest index.
module cbus_rr_pick
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;
  logic          found;

  // First valid requester in search order wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ROUND_ROBIN != 0) begin
        idx = IW'((int'(last) + 1 + k) % NUM_REQ);
      end else begin
        idx = IW'(k);
      end
      if (!found && valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 cbus arbiter: grant is locked for a whole burst.
// Tracks beats and flags upstream/downstream protocol errors.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 iresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       proto_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [CBUS_LW-1:0] beats_q, beats_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] valid_vec;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  cbus_req_t          gnt_req;

  // Collect upstream valids for the picker.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  cbus_rr_pick #(
    .NUM_REQ     (NUM_REQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .valid  (valid_vec),
    .last   (grant_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  assign gnt_req = ireqs[grant_q];

  // Arbitration, beat accounting and sticky error detection.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beats_d = beats_q;
    err_d   = err_q;
    unique case (1'b1)
      (state_q == ARB_IDLE): begin
        if (oresp.ready) begin
          err_d = 1'b1;
        end
        if (pick_any) begin
          grant_d = pick_idx;
          beats_d = ireqs[pick_idx].len;
          state_d = ARB_BUSY;
        end
      end
      (state_q == ARB_BUSY): begin
        if (oresp.last && beats_q != '0) begin
          err_d = 1'b1;
        end
        if (oresp.ready && !oresp.last
            && beats_q == '0) begin
          err_d = 1'b1;
        end
        if (!gnt_req.valid) begin
          err_d = 1'b1;
        end
        if (oresp.ready) begin
          beats_d = beat_dec(beats_q);
        end
        if (oresp.ready && oresp.last) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Route the granted requester only while busy.
  always_comb begin
    oreq = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      iresps[j] = '0;
    end
    if (state_q == ARB_BUSY) begin
      oreq = gnt_req;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (IW'(j) == grant_q) begin
          iresps[j] = oresp;
        end
      end
    end
  end

  // State registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= IW'(NUM_REQ - 1);
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ARB_BUSY);
  assign grant_idx = grant_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with a beat scoreboard.
// A second instance covers fixed-priority mode.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cbus_req_t  ireqs [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] grant_idx;
  logic       proto_err;

  cbus_req_t  ireqs_fp [N];
  cbus_resp_t iresps_fp [N];
  cbus_req_t  oreq_fp;
  cbus_resp_t oresp_fp;
  logic       busy_fp;
  logic [0:0] grant_idx_fp;
  logic       proto_err_fp;

  cbus_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx),
    .proto_err (proto_err)
  );

  cbus_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(0)) dut_fp (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs_fp),
    .iresps    (iresps_fp),
    .oreq      (oreq_fp),
    .oresp     (oresp_fp),
    .busy      (busy_fp),
    .grant_idx (grant_idx_fp),
    .proto_err (proto_err_fp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(logic [31:0] a, int b);
    return {a, 32'hC0DE_0000 | 32'(b)};
  endfunction

  // Memory model: ready every beat, last on len or an early beat.
  int   mbeat;
  int   early_last = -1;
  logic force_rdy = 1'b0;

  always_comb begin
    oresp = '0;
    if (oreq.valid) begin
      oresp.ready = 1'b1;
      oresp.data  = beat_data(oreq.addr, mbeat);
      if (early_last >= 0) oresp.last = (mbeat == early_last);
      else oresp.last = (mbeat == int'(oreq.len));
    end else if (force_rdy) begin
      oresp.ready = 1'b1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) mbeat <= 0;
    else if (oresp.ready && oresp.last) mbeat <= 0;
    else if (oresp.ready && oreq.valid) mbeat <= mbeat + 1;
  end

  always_comb begin
    oresp_fp = '0;
    if (oreq_fp.valid) begin
      oresp_fp.ready = 1'b1;
      oresp_fp.last  = 1'b1;
      oresp_fp.data  = beat_data(oreq_fp.addr, 0);
    end
  end

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   done_cnt = 0;
  int   beat_cnt = 0;
  bit   stray = 1'b0;
  int   fp_cnt [N];
  bit   stray_fp = 1'b0;

  task automatic push_txn(int idx, logic [31:0] addr, int nb);
    for (int b = 0; b < nb; b++) begin
      exp_t e;
      e.idx  = idx;
      e.data = beat_data(addr, b);
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: pop expected beats, flag responses on non-granted ports.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (iresps[k] !== '0 && (!busy || k != int'(grant_idx)))
        stray = 1'b1;
      if (iresps[k].ready === 1'b1) begin
        beat_cnt++;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("beat_idx", k, e.idx);
          chk("beat_data", iresps[k].data, e.data);
          chk("beat_last", iresps[k].last, e.last);
        end
        if (iresps[k].last) done_cnt++;
      end
      if (iresps_fp[k].ready === 1'b1 && iresps_fp[k].last)
        fp_cnt[k]++;
    end
    if (iresps_fp[1] !== '0) stray_fp = 1'b1;
  end

  task automatic clear_tb();
    sb.delete();
    done_cnt   = 0;
    beat_cnt   = 0;
    stray      = 1'b0;
    early_last = -1;
    force_rdy  = 1'b0;
  endtask

  // Hold reset, check reset values; caller releases.
  task automatic do_reset(string tag);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    repeat (2) @(negedge clk);
    clear_tb();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gidx"}, grant_idx, 1);
    chk({tag, "_perr"}, proto_err, 0);
    chk({tag, "_oreq"}, oreq === '0, 1);
    chk({tag, "_resp"}, (iresps[0] === '0) && (iresps[1] === '0), 1);
  endtask

  task automatic wait_done(int n, int budget, string tag);
    int c = 0;
    while (done_cnt < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(tag, done_cnt >= n, 1);
  endtask

  task automatic wait_beats(int n, int budget, string tag);
    int c = 0;
    while (beat_cnt < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(tag, beat_cnt >= n, 1);
  endtask

  function automatic cbus_req_t mk(logic wr, logic [31:0] a,
                                   logic [7:0] strb, logic [63:0] d,
                                   logic [7:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd3;
    r.addr     = a;
    r.strobe   = strb;
    r.data     = d;
    r.len      = len;
    r.burst    = BURST_INCR;
    return r;
  endfunction

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      ireqs[i]    = '0;
      ireqs_fp[i] = '0;
      fp_cnt[i]   = 0;
    end

    // Single requester 1 read burst of 4 beats.
    do_reset("rst1");
    reset = 1'b1;
    @(posedge clk);
    #1;
    ireqs[1] = mk(1'b0, 32'h8000_0000, 8'h00, 64'h0, 8'd3);
    push_txn(1, 32'h8000_0000, 4);
    @(negedge clk);
    chk("t1_busy_pre", busy, 0);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_gidx", grant_idx, 1);
    wait_done(1, 20, "t1_done");
    ireqs[1].valid = 1'b0;
    chk("t1_idle", busy, 0);
    chk("t1_perr", proto_err, 0);
    chk("t1_stray", stray, 0);
    chk("t1_sb", sb.size(), 0);
    chk("t1_beats", beat_cnt, 4);

    // Both valid right after reset: 0,1,0,1.
    do_reset("rst2");
    ireqs[0] = mk(1'b0, 32'h0000_1000, 8'h00, 64'h0, 8'd1);
    ireqs[1] = mk(1'b0, 32'h0000_2000, 8'h00, 64'h0, 8'd2);
    push_txn(0, 32'h0000_1000, 2);
    push_txn(1, 32'h0000_2000, 3);
    push_txn(0, 32'h0000_1000, 2);
    push_txn(1, 32'h0000_2000, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("t2_busy", busy, 1);
    chk("t2_first", grant_idx, 0);
    wait_done(4, 60, "t2_done");
    ireqs[0].valid = 1'b0;
    ireqs[1].valid = 1'b0;
    @(negedge clk);
    chk("t2_idle", busy, 0);
    chk("t2_perr", proto_err, 0);
    chk("t2_stray", stray, 0);
    chk("t2_sb", sb.size(), 0);

    // Early last on beat 3 of a len=7 burst.
    do_reset("rst3");
    ireqs[0] = mk(1'b0, 32'h0000_3000, 8'h00, 64'h0, 8'd7);
    early_last = 3;
    push_txn(0, 32'h0000_3000, 4);
    reset = 1'b1;
    wait_done(1, 30, "t3_done");
    ireqs[0].valid = 1'b0;
    early_last = -1;
    chk("t3_perr", proto_err, 1);
    chk("t3_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("t3_sticky", proto_err, 1);
    chk("t3_idle2", busy, 0);
    ireqs[1] = mk(1'b0, 32'h0000_3100, 8'h00, 64'h0, 8'd0);
    push_txn(1, 32'h0000_3100, 1);
    wait_done(2, 20, "t3_done2");
    ireqs[1].valid = 1'b0;
    chk("t3_sticky2", proto_err, 1);
    chk("t3_sb", sb.size(), 0);

    // Ready seen while idle.
    do_reset("rst4");
    reset = 1'b1;
    @(negedge clk);
    chk("t4_perr_pre", proto_err, 0);
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    chk("t4_perr", proto_err, 1);
    chk("t4_busy", busy, 0);

    // Reset during beat 2 of a len=7 write.
    do_reset("rst5");
    ireqs[0] = mk(1'b1, 32'h0000_5000, 8'hFF,
                  64'hDEAD_BEEF_0000_5555, 8'd7);
    push_txn(0, 32'h0000_5000, 8);
    reset = 1'b1;
    wait_beats(2, 20, "t5_beats");
    chk("t5_valid_mid", oreq.valid, 1);
    reset = 1'b0;
    #1;
    chk("t5_valid_drop", oreq.valid, 0);
    chk("t5_busy_drop", busy, 0);
    chk("t5_resp_drop", iresps[0] === '0, 1);
    ireqs[0].valid = 1'b0;
    @(negedge clk);
    clear_tb();
    chk("t5_gidx_rst", grant_idx, 1);
    ireqs[1] = mk(1'b0, 32'h0000_6000, 8'h00, 64'h0, 8'd0);
    push_txn(1, 32'h0000_6000, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_regrant", grant_idx, 1);
    chk("t5_rebusy", busy, 1);
    wait_done(1, 20, "t5_done");
    ireqs[1].valid = 1'b0;
    chk("t5_perr", proto_err, 0);
    chk("t5_sb", sb.size(), 0);

    // Write from 1 with strobe while 0 waits.
    do_reset("rst6");
    reset = 1'b1;
    @(posedge clk);
    #1;
    ireqs[1] = mk(1'b1, 32'h4060_0004, 8'hF0,
                  64'h1122_3344_5566_7788, 8'd1);
    push_txn(1, 32'h4060_0004, 2);
    @(posedge clk);
    #1;
    ireqs[0] = mk(1'b0, 32'h0000_7000, 8'h00, 64'h0, 8'd0);
    push_txn(0, 32'h0000_7000, 1);
    @(negedge clk);
    chk("t6_gidx", grant_idx, 1);
    chk("t6_strobe", oreq.strobe, 8'hF0);
    chk("t6_data", oreq.data, 64'h1122_3344_5566_7788);
    chk("t6_addr", oreq.addr, 32'h4060_0004);
    chk("t6_wr", oreq.is_write, 1);
    chk("t6_r0_wait", iresps[0].ready, 0);
    wait_done(1, 20, "t6_done1");
    ireqs[1].valid = 1'b0;
    chk("t6_r0_pending", iresps[0].ready, 0);
    wait_done(2, 20, "t6_done2");
    ireqs[0].valid = 1'b0;
    chk("t6_stray", stray, 0);
    chk("t6_perr", proto_err, 0);
    chk("t6_sb", sb.size(), 0);

    // Fixed priority: requester 0 always wins.
    fp_cnt[0] = 0;
    fp_cnt[1] = 0;
    stray_fp  = 1'b0;
    ireqs_fp[0] = mk(1'b0, 32'h0000_A000, 8'h00, 64'h0, 8'd0);
    ireqs_fp[1] = mk(1'b0, 32'h0000_B000, 8'h00, 64'h0, 8'd0);
    c = 0;
    while (fp_cnt[0] + fp_cnt[1] < 4 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    ireqs_fp[0].valid = 1'b0;
    ireqs_fp[1].valid = 1'b0;
    chk("t7_done", fp_cnt[0] + fp_cnt[1] >= 4, 1);
    chk("t7_cnt0", fp_cnt[0], 4);
    chk("t7_cnt1", fp_cnt[1], 0);
    chk("t7_stray", stray_fp, 0);
    chk("t7_perr", proto_err_fp, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
